// File: rtl/line_buffer_ntap.sv
// Multi-line buffer: turns one raster pixel stream into N_TAPS vertically aligned
// pixels per clock using a cascade of column-addressed line RAMs.
module line_buffer_ntap #(
  parameter int DATA_W    = 8,
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int N_TAPS    = 3,
  parameter int EDGE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vs,
  input  logic                     de,
  input  logic [DATA_W-1:0]        din,
  output logic [N_TAPS*DATA_W-1:0] tap_data,
  output logic                     tap_de,
  output logic [11:0]              tap_x,
  output logic [11:0]              tap_y,
  output logic                     border,
  output logic                     line_err
);

  localparam int N_RAM = N_TAPS - 1;
  localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] Y_FULL = 12'(N_TAPS - 1);

  logic              vs_q;
  logic              vs_rise;
  logic [11:0]       h_cnt;
  logic [11:0]       v_cnt;
  logic [11:0]       px_x;
  logic [11:0]       px_y;
  logic              frame_done;
  logic              short_frame;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] ram_rd [N_RAM];
  logic [DATA_W-1:0] rd_q   [N_RAM];
  logic [DATA_W-1:0] raw    [8];

  assign vs_rise = vs & ~vs_q;
  assign px_x    = vs_rise ? 12'd0 : h_cnt;
  assign px_y    = vs_rise ? 12'd0 : v_cnt;
  assign addr    = px_x[AW-1:0];

  // A completed frame leaves v_cnt saturated at the last line; frame_done marks
  // that state so the following vs is not mistaken for a short frame.
  assign short_frame = vs_rise & ~((h_cnt == 12'd0) & ((v_cnt == 12'd0) | frame_done));

  // Asynchronous read gives the old column value in the write cycle (read-first).
  for (genvar j = 0; j < N_RAM; j++) begin : g_ram
    logic [DATA_W-1:0] mem [H_ACTIVE];
    logic [DATA_W-1:0] wr_data;

    if (j == 0) begin : g_first
      assign wr_data = din;
    end else begin : g_next
      assign wr_data = ram_rd[j-1];
    end

    assign ram_rd[j] = mem[addr];

    always_ff @(posedge clk) begin
      if (de) begin
        mem[addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q       <= 1'b0;
      h_cnt      <= 12'd0;
      v_cnt      <= 12'd0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      tap_de     <= 1'b0;
      tap_x      <= 12'd0;
      tap_y      <= 12'd0;
      din_q      <= '0;
      for (int j = 0; j < N_RAM; j++) begin
        rd_q[j] <= '0;
      end
    end else begin
      vs_q   <= vs;
      tap_de <= de;
      if (vs_rise) begin
        h_cnt      <= 12'd0;
        v_cnt      <= 12'd0;
        frame_done <= 1'b0;
      end
      if (short_frame || (de && frame_done && !vs_rise)) begin
        line_err <= 1'b1;
      end
      if (de) begin
        din_q <= din;
        rd_q  <= ram_rd;
        tap_x <= px_x;
        tap_y <= px_y;
        if (px_x == X_LAST) begin
          h_cnt <= 12'd0;
          if (px_y == Y_LAST) begin
            frame_done <= 1'b1;
          end else begin
            v_cnt <= px_y + 12'd1;
          end
        end else begin
          h_cnt <= px_x + 12'd1;
        end
      end
    end
  end

  // Tap k is line y-k; above the top border it is zero or the oldest real line.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      raw[i] = '0;
    end
    raw[0] = din_q;
    for (int j = 0; j < N_RAM; j++) begin
      raw[j+1] = rd_q[j];
    end
    tap_data = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (tap_y >= 12'(k)) begin
        tap_data[k*DATA_W +: DATA_W] = raw[k];
      end else if (EDGE_MODE == 1) begin
        tap_data[k*DATA_W +: DATA_W] = raw[tap_y[2:0]];
      end
    end
  end

  assign border = tap_de & (tap_y < Y_FULL);

endmodule

// File: tb/tb_line_buffer_ntap.sv
// Directed bench for line_buffer_ntap: two 8x6 instances (zero-fill and replicate
// borders) driven together, plus a 24-bit, 5-tap, 16x8 instance.
module tb_line_buffer_ntap;

  logic         clk = 1'b0;
  logic         rst;
  logic         vs, de;
  logic [7:0]   din;
  logic [23:0]  e0_data, e1_data;
  logic         e0_de, e1_de, e0_border, e1_border, e0_err, e1_err;
  logic [11:0]  e0_x, e0_y, e1_x, e1_y;
  logic         w_vs, w_de;
  logic [23:0]  w_din;
  logic [119:0] w_data;
  logic         w_tde, w_border, w_err;
  logic [11:0]  w_x, w_y;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  line_buffer_ntap #(.DATA_W(8), .H_ACTIVE(8), .V_ACTIVE(6), .N_TAPS(3), .EDGE_MODE(0)) u_e0 (
    .clk(clk), .rst(rst), .vs(vs), .de(de), .din(din),
    .tap_data(e0_data), .tap_de(e0_de), .tap_x(e0_x), .tap_y(e0_y),
    .border(e0_border), .line_err(e0_err));

  line_buffer_ntap #(.DATA_W(8), .H_ACTIVE(8), .V_ACTIVE(6), .N_TAPS(3), .EDGE_MODE(1)) u_e1 (
    .clk(clk), .rst(rst), .vs(vs), .de(de), .din(din),
    .tap_data(e1_data), .tap_de(e1_de), .tap_x(e1_x), .tap_y(e1_y),
    .border(e1_border), .line_err(e1_err));

  line_buffer_ntap #(.DATA_W(24), .H_ACTIVE(16), .V_ACTIVE(8), .N_TAPS(5), .EDGE_MODE(0)) u_w (
    .clk(clk), .rst(rst), .vs(w_vs), .de(w_de), .din(w_din),
    .tap_data(w_data), .tap_de(w_tde), .tap_x(w_x), .tap_y(w_y),
    .border(w_border), .line_err(w_err));

  // Reference model for the 8x6 pattern: pixel (x,y) carries {y,x} nibbles.
  function automatic logic [23:0] exp_taps(input int edge_mode, input int x, input int y);
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      if (y >= k) v[k*8 +: 8] = 8'(((y - k) << 4) | x);
      else if (edge_mode == 1) v[k*8 +: 8] = 8'(x);
      else v[k*8 +: 8] = 8'h00;
    end
    return v;
  endfunction

  function automatic logic [23:0] wval(input int x, input int y);
    return 24'h100000 | 24'(y << 8) | 24'(x);
  endfunction

  function automatic logic [119:0] exp_wide(input int x, input int y);
    logic [119:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      if (y >= k) v[k*24 +: 24] = wval(x, y - k);
    end
    return v;
  endfunction

  task automatic put_pixel(input int x, input int y);
    vs = 1'b0;
    de = 1'b1;
    din = 8'((y << 4) | x);
    @(negedge clk);
    de = 1'b0;
  endtask

  task automatic idle();
    de = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_vs();
    vs = 1'b1;
    de = 1'b0;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic put_wide(input int x, input int y);
    w_vs = 1'b0;
    w_de = 1'b1;
    w_din = wval(x, y);
    @(negedge clk);
    w_de = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (e0_data !== 24'h0 || e0_de !== 1'b0 || e0_x !== 12'd0 || e0_y !== 12'd0 ||
        e0_border !== 1'b0 || e0_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_e0 got data=%h de=%b x=%0d y=%0d b=%b err=%b, want all 0",
               e0_data, e0_de, e0_x, e0_y, e0_border, e0_err);
    end
    total++;
    if (e1_data !== 24'h0 || e1_de !== 1'b0 || e1_border !== 1'b0 || e1_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_e1 got data=%h de=%b b=%b err=%b, want all 0",
               e1_data, e1_de, e1_border, e1_err);
    end
    total++;
    if (w_data !== 120'h0 || w_tde !== 1'b0 || w_x !== 12'd0 || w_y !== 12'd0 || w_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_wide got data=%h de=%b x=%0d y=%0d err=%b, want all 0",
               w_data, w_tde, w_x, w_y, w_err);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_edge_modes();
    pulse_vs();
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        put_pixel(x, y);
        total++;
        if (e0_data !== exp_taps(0, x, y) || e0_x !== 12'(x) || e0_y !== 12'(y) ||
            e0_de !== 1'b1 || e0_border !== (y < 2)) begin
          bad++;
          $display("FAIL edge0 at (%0d,%0d) got data=%h x=%0d y=%0d de=%b b=%b, want data=%h",
                   x, y, e0_data, e0_x, e0_y, e0_de, e0_border, exp_taps(0, x, y));
        end
        total++;
        if (e1_data !== exp_taps(1, x, y) || e1_x !== 12'(x) || e1_y !== 12'(y) ||
            e1_de !== 1'b1 || e1_border !== (y < 2)) begin
          bad++;
          $display("FAIL edge1 at (%0d,%0d) got data=%h x=%0d y=%0d de=%b b=%b, want data=%h",
                   x, y, e1_data, e1_x, e1_y, e1_de, e1_border, exp_taps(1, x, y));
        end
        if (x == 5 && y == 3) begin
          total++;
          if (e0_data !== 24'h152535) begin
            bad++;
            $display("FAIL spot_e0_5_3 got %h want 152535", e0_data);
          end
        end
        if (x == 2 && y == 1) begin
          total++;
          if (e0_data[23:16] !== 8'h00 || e0_border !== 1'b1) begin
            bad++;
            $display("FAIL spot_e0_2_1 got tap2=%h b=%b want tap2=00 b=1", e0_data[23:16], e0_border);
          end
          total++;
          if (e1_data[23:8] !== 16'h0202) begin
            bad++;
            $display("FAIL spot_e1_2_1 got tap2,tap1=%h want 0202", e1_data[23:8]);
          end
        end
        if (x == 4 && y == 0) begin
          total++;
          if (e1_data !== 24'h040404) begin
            bad++;
            $display("FAIL spot_e1_4_0 got %h want 040404", e1_data);
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    int de_cnt;
    logic [23:0] prev;
    int prev_x;
    de_cnt = 0;
    prev = exp_taps(0, 7, 5);
    prev_x = 7;
    pulse_vs();
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        repeat ($urandom_range(0, 2)) begin
          idle();
          if (e0_de === 1'b1) de_cnt++;
          total++;
          if (e0_de !== 1'b0 || e0_data !== prev || e0_x !== 12'(prev_x) || e0_border !== 1'b0) begin
            bad++;
            $display("FAIL gap_hold before (%0d,%0d) got de=%b data=%h x=%0d b=%b want de=0 data=%h x=%0d b=0",
                     x, y, e0_de, e0_data, e0_x, e0_border, prev, prev_x);
          end
        end
        put_pixel(x, y);
        if (e0_de === 1'b1) de_cnt++;
        total++;
        if (e0_data !== exp_taps(0, x, y) || e0_x !== 12'(x) || e0_y !== 12'(y) ||
            e1_data !== exp_taps(1, x, y)) begin
          bad++;
          $display("FAIL gap_pixel at (%0d,%0d) got e0=%h e1=%h x=%0d y=%0d want e0=%h e1=%h",
                   x, y, e0_data, e1_data, e0_x, e0_y, exp_taps(0, x, y), exp_taps(1, x, y));
        end
        prev = exp_taps(0, x, y);
        prev_x = x;
      end
    end
    total++;
    if (de_cnt != 48) begin
      bad++;
      $display("FAIL gap_de_count got %0d want 48", de_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    pulse_vs();
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (y < 4 || x < 3) put_pixel(x, y);
      end
    end
    rst = 1'b1;
    de = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (e0_data !== 24'h0 || e0_de !== 1'b0 || e0_x !== 12'd0 || e0_y !== 12'd0 ||
        e0_border !== 1'b0 || e0_err !== 1'b0 || e1_data !== 24'h0) begin
      bad++;
      $display("FAIL midrst_clear got e0=%h de=%b x=%0d y=%0d b=%b err=%b e1=%h want all 0",
               e0_data, e0_de, e0_x, e0_y, e0_border, e0_err, e1_data);
    end
    pulse_vs();
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        put_pixel(x, y);
        total++;
        if (e0_data !== exp_taps(0, x, y) || e1_data !== exp_taps(1, x, y) ||
            e0_border !== (y < 2)) begin
          bad++;
          $display("FAIL midrst_frame at (%0d,%0d) got e0=%h e1=%h b=%b want e0=%h e1=%h",
                   x, y, e0_data, e1_data, e0_border, exp_taps(0, x, y), exp_taps(1, x, y));
        end
      end
    end
    total++;
    if (e0_err !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_err got line_err=%b want 0", e0_err);
    end
  endtask

  task automatic test_short_line();
    pulse_vs();
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (y < 2 || x < 5) put_pixel(x, y);
      end
    end
    pulse_vs();
    total++;
    if (e0_err !== 1'b1 || e1_err !== 1'b1) begin
      bad++;
      $display("FAIL short_line_err got e0=%b e1=%b want 1 1", e0_err, e1_err);
    end
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        put_pixel(x, y);
      end
    end
    pulse_vs();
    total++;
    if (e0_err !== 1'b1) begin
      bad++;
      $display("FAIL short_line_sticky got %b want 1", e0_err);
    end
  endtask

  task automatic test_wide();
    w_vs = 1'b1;
    @(negedge clk);
    w_vs = 1'b0;
    @(negedge clk);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        put_wide(x, y);
        total++;
        if (w_data !== exp_wide(x, y) || w_x !== 12'(x) || w_y !== 12'(y) || w_tde !== 1'b1 ||
            w_border !== (y < 4)) begin
          bad++;
          $display("FAIL wide at (%0d,%0d) got data=%h x=%0d y=%0d de=%b b=%b want data=%h",
                   x, y, w_data, w_x, w_y, w_tde, w_border, exp_wide(x, y));
        end
        if (y == 7) begin
          total++;
          if (w_data[96 +: 24] !== wval(x, 3)) begin
            bad++;
            $display("FAIL wide_tap4_line7 col %0d got %h want %h", x, w_data[96 +: 24], wval(x, 3));
          end
        end
      end
    end
    @(negedge clk);
    total++;
    if (w_tde !== 1'b0 || w_x !== 12'd15 || w_y !== 12'd7 || w_err !== 1'b0) begin
      bad++;
      $display("FAIL wide_idle got de=%b x=%0d y=%0d err=%b want de=0 x=15 y=7 err=0",
               w_tde, w_x, w_y, w_err);
    end
    put_wide(0, 9);
    total++;
    if (w_err !== 1'b1 || w_y !== 12'd7 || w_x !== 12'd0) begin
      bad++;
      $display("FAIL wide_overrun got err=%b x=%0d y=%0d want err=1 x=0 y=7", w_err, w_x, w_y);
    end
    w_vs = 1'b1;
    w_de = 1'b1;
    w_din = 24'hABCDEF;
    @(negedge clk);
    w_vs = 1'b0;
    w_de = 1'b0;
    total++;
    if (w_x !== 12'd0 || w_y !== 12'd0 || w_tde !== 1'b1 || w_data[23:0] !== 24'hABCDEF ||
        w_border !== 1'b1 || w_err !== 1'b1) begin
      bad++;
      $display("FAIL wide_vs_de got x=%0d y=%0d de=%b tap0=%h b=%b err=%b want 0 0 1 abcdef 1 1",
               w_x, w_y, w_tde, w_data[23:0], w_border, w_err);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    vs = 1'b0;
    de = 1'b0;
    din = 8'h00;
    w_vs = 1'b0;
    w_de = 1'b0;
    w_din = 24'h0;
    test_reset();
    test_edge_modes();
    test_gaps();
    test_reset_midframe();
    test_short_line();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
